// File: rtl/bp_wb_bus_guard.sv
// -----------------------------------------------------------------------------
// bp_wb_bus_guard
//
// Purpose:
//   Wishbone transfer guard between the BlackParrot-to-Wishbone convertor
//   (64-bit master side) and the SoC Wishbone bus (slave side). Cycles are
//   forwarded with zero added latency. Every transfer is watched by a timeout
//   counter. If the slave terminates with ERR, or never terminates, the guard
//   hands the master an ACK carrying err_data_p so the convertor cannot hang.
//   Faults are recorded in sticky status registers and saturating counters.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   m_*                     master-side Wishbone (from the convertor)
//   s_*                     bus-side Wishbone (to the SoC interconnect)
//   fault_v_o               sticky "a fault happened" flag
//   fault_adr_o/we_o        address / we of the most recent fault
//   fault_is_to_o           most recent fault was a timeout (1) or ERR (0)
//   timeout_cnt_o/err_cnt_o saturating fault counters
//   fault_clr_i             clears fault_v_o and both counters
// -----------------------------------------------------------------------------
module bp_wb_bus_guard #(
    parameter int          adr_width_p      = 37,
    parameter int          timeout_cycles_p = 1024,
    parameter logic [63:0] err_data_p       = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter int          cnt_width_p      = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,

    input  logic [adr_width_p-1:0] m_adr_i,
    input  logic [63:0]            m_dat_i,
    output logic [63:0]            m_dat_o,
    input  logic [7:0]             m_sel_i,
    input  logic                   m_we_i,
    input  logic                   m_stb_i,
    input  logic                   m_cyc_i,
    output logic                   m_ack_o,

    output logic [adr_width_p-1:0] s_adr_o,
    output logic [63:0]            s_dat_o,
    input  logic [63:0]            s_dat_i,
    output logic [7:0]             s_sel_o,
    output logic                   s_we_o,
    output logic                   s_stb_o,
    output logic                   s_cyc_o,
    input  logic                   s_ack_i,
    input  logic                   s_err_i,

    output logic                   fault_v_o,
    output logic [adr_width_p-1:0] fault_adr_o,
    output logic                   fault_we_o,
    output logic                   fault_is_to_o,
    output logic [cnt_width_p-1:0] timeout_cnt_o,
    output logic [cnt_width_p-1:0] err_cnt_o,
    input  logic                   fault_clr_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e      state_reg;
    logic [15:0] cnt_reg;

    logic stb_eff;
    logic bus_on;
    logic term;
    logic to_fire;
    logic log_err;
    logic log_to;

    logic                   fault_v_reg;
    logic [adr_width_p-1:0] fault_adr_reg;
    logic                   fault_we_reg;
    logic                   fault_is_to_reg;
    logic [cnt_width_p-1:0] timeout_cnt_reg;
    logic [cnt_width_p-1:0] err_cnt_reg;

    assign stb_eff = m_stb_i & m_cyc_i;
    // The bus is cut off for one cycle after a timeout so a slow slave sees
    // the access withdrawn; reset also forces it off.
    assign bus_on  = (state_reg != ST_DRAIN) & ~reset_i;
    assign term    = s_ack_i | s_err_i;
    assign to_fire = (state_reg == ST_WAIT) & stb_eff & ~term & ~reset_i &
                     (cnt_reg == 16'(timeout_cycles_p));

    // Slave terminations in DRAIN are stale leftovers of the abandoned access.
    assign log_err = stb_eff & bus_on & s_err_i;
    assign log_to  = to_fire;

    // Pass-through of the request fields
    assign s_adr_o = m_adr_i;
    assign s_dat_o = m_dat_i;
    assign s_sel_o = m_sel_i;
    assign s_we_o  = m_we_i;
    assign s_stb_o = stb_eff & bus_on;
    assign s_cyc_o = m_cyc_i & bus_on;

    // Zero-latency termination; ERR wins over a simultaneous ACK.
    assign m_ack_o = stb_eff & bus_on & (term | to_fire);
    assign m_dat_o = (s_ack_i & ~s_err_i) ? s_dat_i : err_data_p;

    // Transfer-tracking FSM
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 16'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (stb_eff && !term) begin
                        state_reg <= ST_WAIT;
                        cnt_reg   <= 16'd1;
                    end
                end
                ST_WAIT: begin
                    if (term || !stb_eff) begin
                        state_reg <= ST_IDLE;
                    end else if (to_fire) begin
                        state_reg <= ST_DRAIN;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                ST_DRAIN: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Fault status. A fault logged in the same cycle as fault_clr_i wins:
    // the flag stays set and its counter restarts at 1.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fault_v_reg     <= 1'b0;
            fault_adr_reg   <= '0;
            fault_we_reg    <= 1'b0;
            fault_is_to_reg <= 1'b0;
            timeout_cnt_reg <= '0;
            err_cnt_reg     <= '0;
        end else begin
            if (fault_clr_i) begin
                fault_v_reg     <= 1'b0;
                timeout_cnt_reg <= '0;
                err_cnt_reg     <= '0;
            end
            if (log_err || log_to) begin
                fault_v_reg     <= 1'b1;
                fault_adr_reg   <= m_adr_i;
                fault_we_reg    <= m_we_i;
                fault_is_to_reg <= log_to;
            end
            if (log_to) begin
                if (fault_clr_i) begin
                    timeout_cnt_reg <= cnt_width_p'(1);
                end else if (!(&timeout_cnt_reg)) begin
                    timeout_cnt_reg <= timeout_cnt_reg + cnt_width_p'(1);
                end
            end
            if (log_err) begin
                if (fault_clr_i) begin
                    err_cnt_reg <= cnt_width_p'(1);
                end else if (!(&err_cnt_reg)) begin
                    err_cnt_reg <= err_cnt_reg + cnt_width_p'(1);
                end
            end
        end
    end

    assign fault_v_o     = fault_v_reg;
    assign fault_adr_o   = fault_adr_reg;
    assign fault_we_o    = fault_we_reg;
    assign fault_is_to_o = fault_is_to_reg;
    assign timeout_cnt_o = timeout_cnt_reg;
    assign err_cnt_o     = err_cnt_reg;

endmodule

// File: tb/tb_bp_wb_bus_guard.sv
// -----------------------------------------------------------------------------
// tb_bp_wb_bus_guard
//
// Directed testbench for bp_wb_bus_guard with timeout_cycles_p=8 and
// cnt_width_p=2 (so counter saturation at 3 is reachable quickly).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. "Cycle n" is counted from the rising edge on which a
// transfer's strobe is first seen.
// -----------------------------------------------------------------------------
module tb_bp_wb_bus_guard;

    localparam int TO = 8;
    localparam int AW = 37;
    localparam int CW = 2;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [AW-1:0] m_adr_i;
    logic [63:0]   m_dat_i;
    logic [63:0]   m_dat_o;
    logic [7:0]    m_sel_i;
    logic          m_we_i;
    logic          m_stb_i;
    logic          m_cyc_i;
    logic          m_ack_o;
    logic [AW-1:0] s_adr_o;
    logic [63:0]   s_dat_o;
    logic [63:0]   s_dat_i;
    logic [7:0]    s_sel_o;
    logic          s_we_o;
    logic          s_stb_o;
    logic          s_cyc_o;
    logic          s_ack_i;
    logic          s_err_i;
    logic          fault_v_o;
    logic [AW-1:0] fault_adr_o;
    logic          fault_we_o;
    logic          fault_is_to_o;
    logic [CW-1:0] timeout_cnt_o;
    logic [CW-1:0] err_cnt_o;
    logic          fault_clr_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    bp_wb_bus_guard #(
        .adr_width_p     (AW),
        .timeout_cycles_p(TO),
        .err_data_p      (ONES),
        .cnt_width_p     (CW)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .m_adr_i      (m_adr_i),
        .m_dat_i      (m_dat_i),
        .m_dat_o      (m_dat_o),
        .m_sel_i      (m_sel_i),
        .m_we_i       (m_we_i),
        .m_stb_i      (m_stb_i),
        .m_cyc_i      (m_cyc_i),
        .m_ack_o      (m_ack_o),
        .s_adr_o      (s_adr_o),
        .s_dat_o      (s_dat_o),
        .s_dat_i      (s_dat_i),
        .s_sel_o      (s_sel_o),
        .s_we_o       (s_we_o),
        .s_stb_o      (s_stb_o),
        .s_cyc_o      (s_cyc_o),
        .s_ack_i      (s_ack_i),
        .s_err_i      (s_err_i),
        .fault_v_o    (fault_v_o),
        .fault_adr_o  (fault_adr_o),
        .fault_we_o   (fault_we_o),
        .fault_is_to_o(fault_is_to_o),
        .timeout_cnt_o(timeout_cnt_o),
        .err_cnt_o    (err_cnt_o),
        .fault_clr_i  (fault_clr_i)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic bus_idle();
        m_stb_i     = 1'b0;
        m_cyc_i     = 1'b0;
        s_ack_i     = 1'b0;
        s_err_i     = 1'b0;
        fault_clr_i = 1'b0;
    endtask

    // Starts a transfer the slave never answers and follows it to the
    // synthesized ACK in cycle TO. Inputs are left asserted afterwards.
    task automatic hang_until_timeout(input logic [AW-1:0] adr, input logic we);
        step();
        m_adr_i = adr; m_we_i = we; m_stb_i = 1'b1; m_cyc_i = 1'b1;
        s_ack_i = 1'b0; s_err_i = 1'b0;
        for (int c = 0; c < TO; c++) begin
            sample();
            n_checks++;
            if (m_ack_o !== 1'b0) begin
                $display("FAIL hang_ack_early c%0d: got %b want 0", c, m_ack_o); n_fail++;
            end
            step();
        end
        sample();
        n_checks++;
        if (m_ack_o !== 1'b1) begin
            $display("FAIL timeout_ack: got %b want 1", m_ack_o); n_fail++;
        end
        n_checks++;
        if (m_dat_o !== ONES) begin
            $display("FAIL timeout_dat: got %h want %h", m_dat_o, ONES); n_fail++;
        end
        $display("txn timeout adr=%h we=%b", adr, we);
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = 8'hFF; m_we_i = 1'b0;
        m_stb_i = 1'b1; m_cyc_i = 1'b1; s_dat_i = '0; s_ack_i = 1'b1;
        s_err_i = 1'b0; fault_clr_i = 1'b0;
        step(); step(); sample();
        n_checks++; if (m_ack_o !== 1'b0) begin $display("FAIL rst_ack: got %b want 0", m_ack_o); n_fail++; end
        n_checks++; if (s_stb_o !== 1'b0) begin $display("FAIL rst_stb: got %b want 0", s_stb_o); n_fail++; end
        n_checks++; if (s_cyc_o !== 1'b0) begin $display("FAIL rst_cyc: got %b want 0", s_cyc_o); n_fail++; end
        n_checks++; if (fault_v_o !== 1'b0) begin $display("FAIL rst_fault_v: got %b want 0", fault_v_o); n_fail++; end
        n_checks++; if (fault_adr_o !== '0) begin $display("FAIL rst_fault_adr: got %h want 0", fault_adr_o); n_fail++; end
        n_checks++; if (fault_we_o !== 1'b0 || fault_is_to_o !== 1'b0) begin
            $display("FAIL rst_fault_we_to: got %b%b want 00", fault_we_o, fault_is_to_o); n_fail++; end
        n_checks++; if (timeout_cnt_o !== '0 || err_cnt_o !== '0) begin
            $display("FAIL rst_cnts: got %0d/%0d want 0/0", timeout_cnt_o, err_cnt_o); n_fail++; end
        step();
        reset_i = 1'b0;
        bus_idle();
        sample();
        $display("txn reset");
    endtask

    task automatic test_read_ack();
        step();
        m_adr_i = 37'h1000; m_we_i = 1'b0; m_sel_i = 8'hF0; m_dat_i = 64'hDEAD_BEEF_0000_0001;
        m_stb_i = 1'b1; m_cyc_i = 1'b1;
        sample();
        n_checks++; if (s_stb_o !== 1'b1 || s_cyc_o !== 1'b1) begin
            $display("FAIL fwd_stb_cyc: got %b%b want 11", s_stb_o, s_cyc_o); n_fail++; end
        n_checks++; if (s_adr_o !== 37'h1000 || s_sel_o !== 8'hF0 || s_we_o !== 1'b0) begin
            $display("FAIL fwd_fields: got adr=%h sel=%h we=%b", s_adr_o, s_sel_o, s_we_o); n_fail++; end
        n_checks++; if (s_dat_o !== 64'hDEAD_BEEF_0000_0001) begin
            $display("FAIL fwd_dat: got %h want deadbeef00000001", s_dat_o); n_fail++; end
        for (int c = 1; c < 3; c++) begin
            step(); sample();
            n_checks++; if (m_ack_o !== 1'b0) begin $display("FAIL read_ack_early c%0d: got %b want 0", c, m_ack_o); n_fail++; end
        end
        step();
        s_ack_i = 1'b1; s_dat_i = 64'h1122_3344_5566_7788;
        sample();
        n_checks++; if (m_ack_o !== 1'b1) begin $display("FAIL read_ack: got %b want 1", m_ack_o); n_fail++; end
        n_checks++; if (m_dat_o !== 64'h1122_3344_5566_7788) begin
            $display("FAIL read_dat: got %h want 1122334455667788", m_dat_o); n_fail++; end
        step(); bus_idle(); sample();
        n_checks++; if (fault_v_o !== 1'b0) begin $display("FAIL read_no_fault: got %b want 0", fault_v_o); n_fail++; end
        $display("txn read adr=1000 ack after 3 cycles");
    endtask

    task automatic test_err();
        step();
        m_adr_i = 37'h2000; m_we_i = 1'b0; m_stb_i = 1'b1; m_cyc_i = 1'b1;
        s_ack_i = 1'b1; s_err_i = 1'b1; s_dat_i = 64'h0123_4567_89AB_CDEF;
        sample();
        n_checks++; if (m_ack_o !== 1'b1) begin $display("FAIL err_ack: got %b want 1", m_ack_o); n_fail++; end
        n_checks++; if (m_dat_o !== ONES) begin $display("FAIL err_dat: got %h want %h", m_dat_o, ONES); n_fail++; end
        step(); bus_idle(); sample();
        n_checks++; if (fault_v_o !== 1'b1 || fault_is_to_o !== 1'b0) begin
            $display("FAIL err_flags: got v=%b to=%b want v=1 to=0", fault_v_o, fault_is_to_o); n_fail++; end
        n_checks++; if (err_cnt_o !== 2'd1 || timeout_cnt_o !== 2'd0) begin
            $display("FAIL err_cnts: got err=%0d to=%0d want 1/0", err_cnt_o, timeout_cnt_o); n_fail++; end
        n_checks++; if (fault_adr_o !== 37'h2000) begin $display("FAIL err_adr: got %h want 2000", fault_adr_o); n_fail++; end
        $display("txn read adr=2000 terminated by err+ack");
    endtask

    task automatic test_timeout();
        hang_until_timeout(37'h0C00_0000, 1'b1);
        step(); sample();   // cycle 9: DRAIN, master still asserting
        n_checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
            $display("FAIL drain_bus: got cyc=%b stb=%b want 0/0", s_cyc_o, s_stb_o); n_fail++; end
        n_checks++; if (m_ack_o !== 1'b0) begin $display("FAIL drain_ack: got %b want 0", m_ack_o); n_fail++; end
        n_checks++; if (fault_v_o !== 1'b1 || fault_is_to_o !== 1'b1 || fault_we_o !== 1'b1) begin
            $display("FAIL to_flags: got v=%b to=%b we=%b want 111", fault_v_o, fault_is_to_o, fault_we_o); n_fail++; end
        n_checks++; if (fault_adr_o !== 37'h0C00_0000) begin
            $display("FAIL to_adr: got %h want c000000", fault_adr_o); n_fail++; end
        n_checks++; if (timeout_cnt_o !== 2'd1 || err_cnt_o !== 2'd1) begin
            $display("FAIL to_cnts: got to=%0d err=%0d want 1/1", timeout_cnt_o, err_cnt_o); n_fail++; end
        step(); bus_idle(); sample();
    endtask

    task automatic test_drain_stale();
        hang_until_timeout(37'h3000, 1'b0);
        step();
        s_ack_i = 1'b1; s_dat_i = 64'h5555_5555_5555_5555;
        sample();
        n_checks++; if (m_ack_o !== 1'b0) begin $display("FAIL stale_ack: got %b want 0", m_ack_o); n_fail++; end
        step(); bus_idle(); sample();
        step();
        m_adr_i = 37'h4000; m_stb_i = 1'b1; m_cyc_i = 1'b1;
        sample();
        n_checks++; if (m_ack_o !== 1'b0 || s_cyc_o !== 1'b1) begin
            $display("FAIL post_drain_c0: got ack=%b cyc=%b want 0/1", m_ack_o, s_cyc_o); n_fail++; end
        step(); sample();
        step();
        s_ack_i = 1'b1; s_dat_i = 64'hA5A5_0000_FFFF_5A5A;
        sample();
        n_checks++; if (m_ack_o !== 1'b1 || m_dat_o !== 64'hA5A5_0000_FFFF_5A5A) begin
            $display("FAIL post_drain_read: got ack=%b dat=%h", m_ack_o, m_dat_o); n_fail++; end
        step(); bus_idle(); sample();
        n_checks++; if (timeout_cnt_o !== 2'd2 || fault_adr_o !== 37'h3000) begin
            $display("FAIL post_drain_status: got to=%0d adr=%h want 2/3000", timeout_cnt_o, fault_adr_o); n_fail++; end
        $display("txn stale ack in drain ignored, read adr=4000 ok");
    endtask

    task automatic test_clr();
        step();
        m_adr_i = 37'h5000; m_we_i = 1'b1; m_stb_i = 1'b1; m_cyc_i = 1'b1;
        s_err_i = 1'b1; fault_clr_i = 1'b1;
        sample();
        n_checks++; if (m_ack_o !== 1'b1) begin $display("FAIL clr_err_ack: got %b want 1", m_ack_o); n_fail++; end
        step(); bus_idle(); sample();
        n_checks++; if (fault_v_o !== 1'b1 || err_cnt_o !== 2'd1 || timeout_cnt_o !== 2'd0) begin
            $display("FAIL clr_and_err: got v=%b err=%0d to=%0d want 1/1/0", fault_v_o, err_cnt_o, timeout_cnt_o); n_fail++; end
        step(); fault_clr_i = 1'b1;
        step(); fault_clr_i = 1'b0;
        sample();
        n_checks++; if (fault_v_o !== 1'b0 || err_cnt_o !== 2'd0 || timeout_cnt_o !== 2'd0) begin
            $display("FAIL clr_alone: got v=%b err=%0d to=%0d want 0/0/0", fault_v_o, err_cnt_o, timeout_cnt_o); n_fail++; end
        n_checks++; if (fault_adr_o !== 37'h5000) begin $display("FAIL clr_keeps_adr: got %h want 5000", fault_adr_o); n_fail++; end
        $display("txn err with clr, then clr alone");
    endtask

    task automatic test_reset_mid_wait();
        step();
        m_adr_i = 37'h6000; m_we_i = 1'b0; m_stb_i = 1'b1; m_cyc_i = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step(); sample();
        end
        step(); reset_i = 1'b1; sample();   // cycle 5
        n_checks++; if (m_ack_o !== 1'b0 || s_cyc_o !== 1'b0) begin
            $display("FAIL midrst_outs: got ack=%b cyc=%b want 0/0", m_ack_o, s_cyc_o); n_fail++; end
        step(); reset_i = 1'b0; sample();   // cycle 6: IDLE, new transfer starts
        n_checks++; if (s_cyc_o !== 1'b1) begin $display("FAIL midrst_cyc: got %b want 1", s_cyc_o); n_fail++; end
        for (int c = 6; c < 6 + TO; c++) begin
            if (c > 6) begin step(); sample(); end
            n_checks++; if (m_ack_o !== 1'b0) begin $display("FAIL midrst_ack c%0d: got %b want 0", c, m_ack_o); n_fail++; end
        end
        n_checks++; if (fault_v_o !== 1'b0 || timeout_cnt_o !== 2'd0) begin
            $display("FAIL midrst_status: got v=%b to=%0d want 0/0", fault_v_o, timeout_cnt_o); n_fail++; end
        step(); sample();   // cycle 14: timeout counted from the restart at cycle 6
        n_checks++; if (m_ack_o !== 1'b1) begin $display("FAIL midrst_restart_ack: got %b want 1", m_ack_o); n_fail++; end
        step(); bus_idle(); sample();
        step(); sample();
        $display("txn reset in wait, restarted timeout");
    endtask

    task automatic test_saturation();
        step(); fault_clr_i = 1'b1;
        step(); fault_clr_i = 1'b0; sample();
        n_checks++; if (timeout_cnt_o !== 2'd0) begin $display("FAIL sat_clr: got %0d want 0", timeout_cnt_o); n_fail++; end
        for (int k = 1; k <= 4; k++) begin
            hang_until_timeout(37'h7000 + 37'(k), 1'b1);
            step(); bus_idle(); sample();
            n_checks++; if (timeout_cnt_o !== ((k > 3) ? 2'd3 : 2'(k))) begin
                $display("FAIL sat_cnt k%0d: got %0d want %0d", k, timeout_cnt_o, (k > 3) ? 3 : k); n_fail++; end
        end
    endtask

    initial begin
        test_reset();
        test_read_ack();
        test_err();
        test_timeout();
        test_drain_stale();
        test_clr();
        test_reset_mid_wait();
        test_saturation();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
